// File: rtl/bcd_pkg.sv
// Shared constants, datapath action codes and BCD validity helpers for the
// N-digit BCD counter.
package bcd_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;
  localparam int         MAX_W      = BCD_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_SET  = 2'd1,
    ACT_STEP = 2'd2
  } act_e;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

  // Only the lowest n digits of the zero-extended vector are examined.
  function automatic logic bcd_vec_valid(input logic [MAX_W-1:0] vec, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && !is_bcd(vec[i*BCD_W +: BCD_W])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_counter_ndigit_digit.sv
// One BCD digit cell: 4-bit register with a parallel set path and an
// up/down step that ripples carry/borrow to the next digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_en_i,
  input  logic [3:0] set_val_i,
  input  logic       step_en_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic       cout_o,
  output logic [3:0] q_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       at_max_s;
  logic       at_min_s;

  assign at_max_s = (digit_q == BCD_MAX);
  assign at_min_s = (digit_q == 4'd0);

  // The chain propagates independent of step_en so the top can read the final
  // borrow as an all-zero detect.
  assign cout_o = cin_i & (up_i ? at_max_s : at_min_s);
  assign q_o    = digit_q;

  // Next digit value: set has priority over a chained step
  always_comb begin
    digit_d = digit_q;
    if (set_en_i) begin
      digit_d = set_val_i;
    end else if (step_en_i && cin_i) begin
      if (up_i) begin
        digit_d = at_max_s ? 4'd0 : (digit_q + 4'd1);
      end else begin
        digit_d = at_min_s ? BCD_MAX : (digit_q - 4'd1);
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Parametrised N-digit BCD up/down counter with clear, checked parallel load,
// programmable terminal value and wrap/saturate behaviour at the bounds.
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                inc,
  input  logic                dec,
  input  logic [4*DIGITS-1:0] limit,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  act_e         act_s;
  logic [W-1:0] set_val_s;
  logic         set_en_s;
  logic         step_en_s;
  logic         up_s;
  logic [DIGITS:0] chain_s;
  logic         q_ge_limit_s;
  logic         q_gt_limit_s;
  logic         load_ok_s;
  logic         q_zero_s;
  logic         err_q;
  logic         err_d;

  // Valid BCD orders like binary, so the bounds are plain unsigned compares.
  assign q_ge_limit_s = (q >= limit);
  assign q_gt_limit_s = (q > limit);
  assign load_ok_s    = bcd_vec_valid(MAX_W'(load_val), DIGITS);

  // With the chain seeded at 1 and direction down, the last borrow means q == 0.
  assign up_s       = !dec;
  assign chain_s[0] = 1'b1;
  assign q_zero_s   = chain_s[DIGITS];

  assign set_en_s  = (act_s == ACT_SET);
  assign step_en_s = (act_s == ACT_STEP);
  assign err       = err_q;

  // Action select: clr > load > single-direction step, plus bound handling
  always_comb begin
    act_s     = ACT_HOLD;
    set_val_s = '0;
    err_d     = err_q;
    tc        = 1'b0;
    if (clr) begin
      act_s     = ACT_SET;
      set_val_s = '0;
      err_d     = 1'b0;
    end else if (load) begin
      if (load_ok_s) begin
        act_s     = ACT_SET;
        set_val_s = load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (inc && !dec) begin
      if (q_ge_limit_s) begin
        tc        = 1'b1;
        act_s     = ACT_SET;
        set_val_s = SATURATE ? limit : '0;
      end else begin
        act_s = ACT_STEP;
      end
    end else if (dec && !inc) begin
      if (q_zero_s) begin
        tc = 1'b1;
        if (SATURATE) begin
          act_s = ACT_HOLD;
        end else begin
          act_s     = ACT_SET;
          set_val_s = limit;
        end
      end else if (SATURATE && q_gt_limit_s) begin
        act_s     = ACT_SET;
        set_val_s = limit;
      end else begin
        act_s = ACT_STEP;
      end
    end else begin
      act_s = ACT_HOLD;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk_i     (clk),
      .rst_i     (reset),
      .set_en_i  (set_en_s),
      .set_val_i (set_val_s[4*i +: 4]),
      .step_en_i (step_en_s),
      .up_i      (up_s),
      .cin_i     (chain_s[i]),
      .cout_o    (chain_s[i+1]),
      .q_o       (q[4*i +: 4])
    );
  end

  // Sticky non-BCD load flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

Parametrised N-digit BCD up/down counter with synchronous clear, parallel load, programmable terminal value and a wrap or saturate mode. It generalises the fixed 3-digit increment-only counter and serves display, event-tally and timer blocks that need arbitrary decimal width, down-counting or a modulus other than 10^N. Each digit is one cascaded BCD cell. A shared compare stage produces the terminal-count and bound logic.

## Interface
- DIGITS, 3: number of BCD digits, 1..8; vector width W = 4*DIGITS
- SATURATE, 0: 0 = wrap at bounds, 1 = hold at bounds
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr  in  1  synchronous clear: q <= 0, err <= 0
- load  in  1  synchronous parallel load of load_val
- load_val  in  W  load value, digit i at [4i+3:4i]
- inc  in  1  count up one step
- dec  in  1  count down one step
- limit  in  W  upper bound (BCD); the count sequence is 0..limit
- q  out  W  registered count, digit 0 = least significant
- tc  out  1  combinational terminal count for this cycle's step
- err  out  1  sticky: load attempted with a non-BCD digit

## Operation
- Reset values: q = 0, err = 0. tc follows its inputs.
- Per-cycle priority: clr > load > (inc XOR dec). Nothing else acts in that cycle.
- load with every load_val digit ≤ 9: q <= load_val. The value may exceed limit.
- load with any load_val digit > 9: q unchanged, err <= 1. err stays set until clr or reset.
- inc and dec both high, or both low: q holds, tc = 0.
- Up step, q < limit: BCD +1. Digit 9 becomes 0 and carries into the next digit.
- Up step, q ≥ limit:
  - SATURATE=0: q <= 0
  - SATURATE=1: q <= limit
- Down step, q > 0: BCD −1. Digit 0 becomes 9 and borrows from the next digit.
- Down step, q > limit: q <= limit when SATURATE=1. When SATURATE=0 it decrements normally.
- Down step, q = 0:
  - SATURATE=0: q <= limit
  - SATURATE=1: q holds
- tc = !clr & !load & ((inc & !dec & q ≥ limit) | (dec & !inc & q == 0)). It flags the step that wraps or saturates.
- Comparison: valid BCD vectors order the same as binary, so q ≥ limit is a plain W-bit unsigned compare.
- limit containing a digit > 9 is illegal. Behaviour with it is unspecified. The verifier checks with an assertion only.

## Timing
- q updates on the clk rising edge after the qualifying inputs. Latency is 1 cycle.
- tc is combinational from q, limit, inc, dec, load and clr in the same cycle. It is not registered.
- reset asserted mid-count forces q = 0 and err = 0 immediately. The first count step after reset release takes effect on the next rising edge.
- limit may change at any cycle. It takes effect on the next step, with no pipelining.

## Structure
- Package bcd_pkg:
  - BCD_W = 4, BCD_MAX = 4'd9
  - function is_bcd(digit)
  - function bcd_vec_valid(vec, n)
- Sub-module bcd_digit: one 4-bit register plus carry-in/borrow-in and carry-out/borrow-out logic.
- bcd_digit is instantiated DIGITS times in a generate loop, with the carry/borrow chain from digit 0 upward.
- The top level holds clr/load/bound muxing, the compare and the err flop.

## Test plan
- DIGITS=3, SATURATE=0, limit=999. Reset, then inc for 1000 cycles → q steps 000..999 then 000. tc=1 only in the cycle where q=999 and inc=1.
- limit=059, load 058, inc ×2 → q=059, then 000. tc=1 on the second inc. dec from 000 → q=059 with tc=1.
- SATURATE=1, limit=120, q=120:
  - inc → q stays 120, tc=1
  - load 000 then dec → q stays 000, tc=1
- load_val=0x1A3 → q unchanged, err=1. Then load 123 → q=123 and err stays 1. Then clr → q=000, err=0.
- Priority checks:
  - clr+load+inc in the same cycle → q=000
  - load 456 + inc → q=456
  - inc+dec together at q=456 → q=456, tc=0
- Async reset asserted between clock edges while q=789 → q=000 immediately, with no clk edge required.
